// File: rtl/xor_parity_seq.sv
// xor_parity_seq: nibble-serial parity of a WIDTH-bit word via one xor4bits cell (clk, rst, start/data_in in; ready, busy, done, parity, nib_count out)
module xor4bits (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y
);
  assign y = a ^ b ^ c ^ d;
endmodule

module xor_parity_seq #(
  parameter int WIDTH = 16,
  parameter bit ODD   = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [WIDTH-1:0]                data_in,
  output logic                            ready,
  output logic                            busy,
  output logic                            done,
  output logic                            parity,
  output logic [$clog2(WIDTH/4+0)+0:0]    nib_count
);
  localparam int NIBS = WIDTH / 4;
  localparam int CW = $clog2(NIBS) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             acc;
  logic [CW-1:0]    cnt;
  logic             y;
  xor4bits u_x (.a(shreg[3]), .b(shreg[2]), .c(shreg[1]), .d(shreg[0]), .y(y));
  assign ready     = state == IDLE;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign nib_count = cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      acc    <= 1'b0;
      cnt    <= '0;
      parity <= ODD;
    end else begin
      case (state)
        IDLE: if (start) begin
          shreg <= data_in;
          acc   <= 1'b0;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          acc   <= acc ^ y;
          shreg <= shreg >> 4;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NIBS - 1)) begin
            parity <= acc ^ y ^ ODD;
            state  <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xor_parity_seq.sv
// tb_xor_parity_seq: randomized self-checking bench for xor_parity_seq with even and odd instances
module tb_xor_parity_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] data_in = '0;
  logic        ready0, busy0, done0, par0;
  logic        ready1, busy1, done1, par1;
  logic [2:0]  nc0, nc1;
  int total = 0;
  int bad = 0;

  xor_parity_seq #(.WIDTH(16), .ODD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .ready(ready0), .busy(busy0), .done(done0), .parity(par0), .nib_count(nc0)
  );
  xor_parity_seq #(.WIDTH(16), .ODD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .ready(ready1), .busy(busy1), .done(done1), .parity(par1), .nib_count(nc1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_word(input logic [15:0] w, input int poke, output int lat, output int ndone);
    int guard;
    guard = 0;
    while (!ready0 && guard < 20) begin
      tick();
      guard++;
    end
    start = 1'b1;
    data_in = w;
    tick();
    start = 1'b0;
    data_in = 16'($urandom);
    lat = -1;
    ndone = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == poke) begin
        start = 1'b1;
        data_in = 16'hFFFF;
      end
      tick();
      start = 1'b0;
      if (done0) begin
        ndone++;
        if (lat < 0) lat = i;
      end
      if (ready0) break;
    end
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    tick();
    tick();
    total++; if (ready0 !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done0); end
    total++; if (par0 !== 1'b0) begin bad++; $display("FAIL reset_par_even: got %b want 0", par0); end
    total++; if (par1 !== 1'b1) begin bad++; $display("FAIL reset_par_odd: got %b want 1", par1); end
    total++; if (nc0 !== 3'd0) begin bad++; $display("FAIL reset_nib: got %0d want 0", nc0); end
    rst = 1'b0;
    tick();
    start = 1'b1;
    data_in = 16'h0000;
    tick();
    start = 1'b0;
    total++; if (ready0 !== 1'b0 || busy0 !== 1'b1) begin bad++; $display("FAIL accept_ready: got ready=%b busy=%b want 0/1", ready0, busy0); end
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      tick();
      if (done0) lat = i;
    end
    total++; if (lat !== 4) begin bad++; $display("FAIL first_latency: got %0d want 4", lat); end
    total++; if (par0 !== 1'b0) begin bad++; $display("FAIL zero_par_even: got %b want 0", par0); end
    total++; if (par1 !== 1'b1) begin bad++; $display("FAIL zero_par_odd: got %b want 1", par1); end
    total++; if (nc0 !== 3'd4) begin bad++; $display("FAIL zero_nib: got %0d want 4", nc0); end
  endtask

  task automatic test_vectors();
    logic [15:0] words [4] = '{16'h0001, 16'h8423, 16'hFFFF, 16'h8421};
    int lat, nd;
    logic p;
    for (int k = 0; k < 4; k++) begin
      run_word(words[k], 0, lat, nd);
      p = ^words[k];
      total++; if (lat !== 4) begin bad++; $display("FAIL vec_latency[%0d]: got %0d want 4", k, lat); end
      total++; if (nd !== 1) begin bad++; $display("FAIL vec_done_count[%0d]: got %0d want 1", k, nd); end
      total++; if (par0 !== p) begin bad++; $display("FAIL vec_par_even[%0d]: got %b want %b", k, par0, p); end
      total++; if (par1 !== ~p) begin bad++; $display("FAIL vec_par_odd[%0d]: got %b want %b", k, par1, ~p); end
      total++; if (nc0 !== 3'd4) begin bad++; $display("FAIL vec_nib[%0d]: got %0d want 4", k, nc0); end
      for (int j = 0; j < 3; j++) begin
        data_in = 16'($urandom);
        tick();
        total++; if (par0 !== p || ready0 !== 1'b1) begin bad++; $display("FAIL idle_hold[%0d]: got par=%b ready=%b want %b/1", k, par0, ready0, p); end
      end
    end
  endtask

  task automatic test_ignore();
    int lat, nd;
    run_word(16'h0001, 2, lat, nd);
    total++; if (nd !== 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
    total++; if (par0 !== 1'b1) begin bad++; $display("FAIL ignore_par: got %b want 1", par0); end
    total++; if (lat !== 4) begin bad++; $display("FAIL ignore_latency: got %0d want 4", lat); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] wq [3];
    int acc_cyc [3];
    int nacc, ndn;
    nacc = 0;
    ndn = 0;
    for (int k = 0; k < 3; k++) wq[k] = 16'($urandom);
    start = 1'b1;
    for (int c = 0; c < 40 && ndn < 3; c++) begin
      if (ready0 && nacc < 3) begin
        data_in = wq[nacc];
        acc_cyc[nacc] = c;
        nacc++;
      end else if (nacc == 3) start = 1'b0;
      tick();
      if (done0) begin
        total++; if (ndn < 3 && par0 !== ^wq[ndn]) begin bad++; $display("FAIL b2b_par[%0d]: got %b want %b", ndn, par0, ^wq[ndn]); end
        ndn++;
      end
    end
    start = 1'b0;
    total++; if (ndn !== 3) begin bad++; $display("FAIL b2b_done_count: got %0d want 3", ndn); end
    total++; if (nacc !== 3 || acc_cyc[1] - acc_cyc[0] !== 6) begin bad++; $display("FAIL b2b_gap01: got %0d want 6", acc_cyc[1] - acc_cyc[0]); end
    total++; if (nacc !== 3 || acc_cyc[2] - acc_cyc[1] !== 6) begin bad++; $display("FAIL b2b_gap12: got %0d want 6", acc_cyc[2] - acc_cyc[1]); end
  endtask

  task automatic test_mid_reset();
    int lat, nd;
    run_word(16'h0001, 0, lat, nd);
    total++; if (par0 !== 1'b1) begin bad++; $display("FAIL mid_pre_par: got %b want 1", par0); end
    start = 1'b1;
    data_in = 16'h1234;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (ready0 !== 1'b1 || busy0 !== 1'b0) begin bad++; $display("FAIL mid_rst_state: got ready=%b busy=%b want 1/0", ready0, busy0); end
    total++; if (par0 !== 1'b0 || par1 !== 1'b1) begin bad++; $display("FAIL mid_rst_par: got %b/%b want 0/1", par0, par1); end
    total++; if (nc0 !== 3'd0) begin bad++; $display("FAIL mid_rst_nib: got %0d want 0", nc0); end
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      if (done0) nd++;
      tick();
    end
    total++; if (nd !== 0) begin bad++; $display("FAIL mid_rst_no_done: got %0d want 0", nd); end
    run_word(16'h0007, 0, lat, nd);
    total++; if (par0 !== 1'b1 || par1 !== 1'b0) begin bad++; $display("FAIL post_rst_par: got %b/%b want 1/0", par0, par1); end
  endtask

  task automatic test_random();
    logic [15:0] w;
    int lat, nd;
    for (int k = 0; k < 16; k++) begin
      w = 16'($urandom);
      run_word(w, (k % 3 == 0) ? 3 : 0, lat, nd);
      total++; if (par0 !== ^w || par1 !== ~^w || nd !== 1) begin bad++; $display("FAIL rand[%0d] w=%h: got %b/%b done=%0d want %b/%b done=1", k, w, par0, par1, nd, ^w, ~^w); end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
